// File: rtl/signed_nibble_counter.sv
// Debounced pushbutton-driven 4-bit two's-complement up/down counter with
// parallel load, wrap/saturate overflow handling and a sticky overflow flag.
module signed_nibble_counter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit SATURATE        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       key_ld_n,
    input  logic [3:0] sw_in,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       ovf
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int              KEY_UP   = 0;
    localparam int              KEY_DN   = 1;
    localparam int              KEY_LD   = 2;
    localparam logic [3:0]      MAX_POS  = 4'b0111;
    localparam logic [3:0]      MIN_NEG  = 4'b1000;

    logic [2:0]    w_keys_n;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_stable;
    logic [2:0]    r_stable_d;
    logic [2:0]    r_evt;
    logic [CW-1:0] r_db_cnt [3];
    logic [3:0]    r_value;
    logic          r_ovf;
    logic [3:0]    w_value_nxt;
    logic          w_ovf_nxt;

    assign w_keys_n = {key_ld_n, key_dn_n, key_up_n};

    // Identical synchronizer + debouncer per key; an event is a registered
    // pulse one cycle after the stable level falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 3'b111;
            r_sync2    <= 3'b111;
            r_stable   <= 3'b111;
            r_stable_d <= 3'b111;
            r_evt      <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= w_keys_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_evt      <= r_stable_d & ~r_stable;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Load wins over steps; up and dn together cancel out.
    always_comb begin
        w_value_nxt = r_value;
        w_ovf_nxt   = r_ovf;
        if (r_evt[KEY_LD]) begin
            w_value_nxt = sw_in;
            w_ovf_nxt   = 1'b0;
        end else if (r_evt[KEY_UP] && !r_evt[KEY_DN]) begin
            if (r_value == MAX_POS) begin
                w_ovf_nxt   = 1'b1;
                w_value_nxt = SATURATE ? MAX_POS : MIN_NEG;
            end else begin
                w_value_nxt = r_value + 4'd1;
            end
        end else if (r_evt[KEY_DN] && !r_evt[KEY_UP]) begin
            if (r_value == MIN_NEG) begin
                w_ovf_nxt   = 1'b1;
                w_value_nxt = SATURATE ? MIN_NEG : MAX_POS;
            end else begin
                w_value_nxt = r_value - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 4'b0000;
            r_ovf   <= 1'b0;
        end else begin
            r_value <= w_value_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign {w, x, y, z} = r_value;
    assign ovf          = r_ovf;

endmodule

// File: tb/tb_signed_nibble_counter.sv
// Bench for signed_nibble_counter: one wrapping and one saturating instance
// share the key inputs and are scored against an integer-arithmetic model.
module tb_signed_nibble_counter;

    localparam int DC = 4;
    localparam int EW = 10;

    logic clk;
    logic rst_n;
    logic key_up_n;
    logic key_dn_n;
    logic key_ld_n;
    logic [3:0] sw_in;
    logic w0, x0, y0, z0, ovf0;
    logic w1, x1, y1, z1, ovf1;

    signed_nibble_counter #(.DEBOUNCE_CYCLES(DC), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .key_ld_n(key_ld_n), .sw_in(sw_in),
        .w(w0), .x(x0), .y(y0), .z(z0), .ovf(ovf0)
    );

    signed_nibble_counter #(.DEBOUNCE_CYCLES(DC), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .key_ld_n(key_ld_n), .sw_in(sw_in),
        .w(w1), .x(x1), .y(y1), .z(z1), .ovf(ovf1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int mv [2];
    bit mo [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0;
            mo[m] = 1'b0;
        end
    endfunction

    function automatic void model_press(bit up, bit dn, bit ld, logic [3:0] sw);
        for (int m = 0; m < 2; m++) begin
            int n;
            if (ld) begin
                mv[m] = int'($signed(sw));
                mo[m] = 1'b0;
            end else if (up != dn) begin
                n = mv[m] + (up ? 1 : -1);
                if (n > 7) begin
                    mo[m] = 1'b1;
                    n = (m == 1) ? 7 : -8;
                end else if (n < -8) begin
                    mo[m] = 1'b1;
                    n = (m == 1) ? -8 : 7;
                end
                mv[m] = n;
            end
        end
    endfunction

    function automatic logic [EW-1:0] model_word();
        logic [3:0] v0;
        logic [3:0] v1;
        v0 = 4'(mv[0]);
        v1 = 4'(mv[1]);
        return {v0, mo[0], v1, mo[1]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [EW-1:0] dut_word();
        return {w0, x0, y0, z0, ovf0, w1, x1, y1, z1, ovf1};
    endfunction

    task automatic push_exp(input int at_cyc, input logic [EW-1:0] e);
        exp_q.push_back(e);
        exp_cyc_q.push_back(at_cyc);
    endtask

    // Monitor: compares each expectation on the exact cycle it is due.
    always @(negedge clk) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            n_checks++;
            $display("FAIL missed_check due_cyc=%0d now=%0d exp=%b", exp_cyc_q[0], cyc, exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            n_checks++;
            if (dut_word() === e) n_pass++;
            else $display("FAIL value_chk cyc=%0d got={v0,o0,v1,o1}=%b exp=%b", cyc, dut_word(), e);
        end
    end

    task automatic check_now(input string name, input logic [EW-1:0] e);
        n_checks++;
        if (dut_word() === e) n_pass++;
        else $display("FAIL %s got=%b exp=%b", name, dut_word(), e);
    endtask

    // ---------------- driver tasks ----------------
    // Keys fall just after a negedge; the next posedge is the capture edge E
    // and the value must change exactly 7 edges later.
    task automatic do_press(input bit up, input bit dn, input bit ld,
                            input logic [3:0] sw, input int hold);
        logic [EW-1:0] pre;
        @(negedge clk);
        sw_in    = sw;
        key_up_n = ~up;
        key_dn_n = ~dn;
        key_ld_n = ~ld;
        pre = model_word();
        model_press(up, dn, ld, sw);
        if (up || dn || ld) begin
            push_exp(cyc + DC + 3, pre);
            push_exp(cyc + DC + 4, model_word());
        end
        repeat (hold) @(negedge clk);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        key_ld_n = 1'b1;
        repeat (DC + 4) @(negedge clk);
    endtask

    task automatic do_bounce_dn();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            key_dn_n = 1'b0;
            repeat (2) @(negedge clk);
            key_dn_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        push_exp(cyc + 20, model_word());
        repeat (22) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        key_ld_n = 1'b1;
        sw_in    = 4'b0000;
        model_reset();
        #23;
        check_now("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_press(1, 0, 0, 4'h0, 20);           // 0000 -> 0001, latency 7
        do_bounce_dn();                        // bounces never accepted

        do_press(0, 0, 1, 4'b0110, 10);
        do_press(1, 0, 0, 4'b0110, 10);
        do_press(1, 0, 0, 4'b0110, 10);        // overflow at +7

        do_press(0, 0, 1, 4'b1000, 10);
        do_press(0, 1, 0, 4'b1000, 10);        // overflow at -8
        do_press(0, 0, 1, 4'b0000, 10);        // load clears ovf

        do_press(0, 0, 1, 4'b0011, 10);
        do_press(1, 1, 0, 4'b0011, 10);        // up+dn cancel
        do_press(1, 1, 1, 4'b1101, 10);        // load dominates

        for (int i = 0; i < 24; i++) begin
            logic [2:0] k;
            k = 3'($urandom_range(1, 7));
            do_press(k[0], k[1], k[2], 4'($urandom_range(0, 15)), $urandom_range(8, 14));
        end

        // Reset mid-debounce with up held, then release reset still held.
        do_press(0, 0, 1, 4'b0101, 10);
        @(negedge clk);
        key_up_n = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async_reset", model_word());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(cyc + DC + 3, model_word());
        model_press(1, 0, 0, 4'h0);
        push_exp(cyc + DC + 4, model_word());
        repeat (12) @(negedge clk);
        key_up_n = 1'b1;
        repeat (DC + 4) @(negedge clk);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
